// File: rtl/serial_pkg.sv
// serial_pkg -- shared definitions for the serial frame transmitter.
//   tx_state_t       : transmit FSM state encoding (3 bits)
//   DEF_DATA_W       : default data bits per frame
//   DEF_CLKS_PER_BIT : default clk cycles per serial bit
package serial_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam int DEF_DATA_W       = 8;
    localparam int DEF_CLKS_PER_BIT = 1;

endpackage

// File: rtl/serial_fifo.sv
// serial_fifo -- word buffer between the host interface and the serializer.
// Show-ahead read: rdata is the head word whenever empty is low.
// Ports:
//   clk, reset      : clock, async active-high reset (buffer emptied)
//   push, wdata     : write request / word; ignored while full
//   pop             : drop head word; ignored while empty
//   rdata           : head word
//   full, empty     : occupancy flags
module serial_fifo
    import serial_pkg::*;
#(
    parameter int WIDTH = DEF_DATA_W,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    // One extra pointer bit distinguishes full from empty.
    logic [AW:0]      wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/serial_frame_tx.sv
// serial_frame_tx -- buffered asynchronous-serial frame transmitter.
// Frame: start(0), DATA_W data bits LSB first, optional parity, STOP_BITS stop(1).
// Optional feature: define SERIAL_FRAME_TX_PARITY_EN to insert a parity bit
// (even, or odd when PARITY_ODD=1) between data and stop.
// Ports:
//   clk, reset          : clock, async active-high reset
//   tx_data, tx_valid   : word to send / valid
//   tx_ready            : buffer not full
//   tx                  : registered serial line, idle high
//   busy                : frame in progress or buffer non-empty
//   frame_cnt           : completed frames, wraps at 16 bits
module serial_frame_tx
    import serial_pkg::*;
#(
    parameter int DATA_W       = DEF_DATA_W,
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4,
    parameter int PARITY_ODD   = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx,
    output logic              busy,
    output logic [15:0]       frame_cnt
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = $clog2(DATA_W);
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);
    localparam logic          STOP_LAST = (STOP_BITS == 2);

    tx_state_t         state;
    logic [DATA_W-1:0] shreg;
    logic [CW-1:0]     clk_cnt;
    logic [BW-1:0]     bit_idx;
    logic              stop_idx;
    logic              tx_q;
    logic [15:0]       frame_cnt_q;
    logic [DATA_W-1:0] head;
    logic              full, empty, pop, bit_end, frame_end;

    serial_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (tx_valid),
        .pop   (pop),
        .wdata (tx_data),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    assign bit_end   = (clk_cnt == CNT_LAST);
    assign frame_end = (state == STOP) && bit_end && (stop_idx == STOP_LAST);
    // Pop from IDLE, or at the end of a frame so the next START follows with no gap.
    assign pop       = !empty && ((state == IDLE) || frame_end);

    assign tx_ready  = !full;
    assign tx        = tx_q;
    assign busy      = (state != IDLE) || !empty;
    assign frame_cnt = frame_cnt_q;

`ifdef SERIAL_FRAME_TX_PARITY_EN
    logic par_q;
`else
    logic unused_parity_odd;
    assign unused_parity_odd = (PARITY_ODD != 0);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            shreg       <= '0;
            clk_cnt     <= '0;
            bit_idx     <= '0;
            stop_idx    <= 1'b0;
            tx_q        <= 1'b1;
            frame_cnt_q <= '0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            // Bit-period counter restarts at every bit boundary and while idle.
            clk_cnt <= (bit_end || state == IDLE) ? '0 : clk_cnt + 1'b1;
            case (state)
                IDLE: begin
                    tx_q <= 1'b1;
                    if (!empty) begin
                        shreg <= head;
                        state <= START;
                        tx_q  <= 1'b0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
                        par_q <= (^head) ^ (PARITY_ODD != 0);
`endif
                    end
                end
                START: if (bit_end) begin
                    state   <= DATA;
                    bit_idx <= '0;
                    tx_q    <= shreg[0];
                end
                DATA: if (bit_end) begin
                    if (bit_idx == BIT_LAST) begin
`ifdef SERIAL_FRAME_TX_PARITY_EN
                        state    <= PARITY;
                        tx_q     <= par_q;
`else
                        state    <= STOP;
                        stop_idx <= 1'b0;
                        tx_q     <= 1'b1;
`endif
                    end else begin
                        bit_idx <= bit_idx + 1'b1;
                        shreg   <= shreg >> 1;
                        tx_q    <= shreg[1];
                    end
                end
`ifdef SERIAL_FRAME_TX_PARITY_EN
                PARITY: if (bit_end) begin
                    state    <= STOP;
                    stop_idx <= 1'b0;
                    tx_q     <= 1'b1;
                end
`endif
                STOP: if (bit_end) begin
                    if (stop_idx == STOP_LAST) begin
                        frame_cnt_q <= frame_cnt_q + 1'b1;
                        if (!empty) begin
                            shreg <= head;
                            state <= START;
                            tx_q  <= 1'b0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
                            par_q <= (^head) ^ (PARITY_ODD != 0);
`endif
                        end else begin
                            state <= IDLE;
                            tx_q  <= 1'b1;
                        end
                    end else begin
                        stop_idx <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx_q  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_frame_tx.sv
// tb_serial_frame_tx -- directed bench for serial_frame_tx.
// u0: defaults; u1: CLKS_PER_BIT=4; u2: PARITY_ODD=1, STOP_BITS=2.
module tb_serial_frame_tx;

`ifdef SERIAL_FRAME_TX_PARITY_EN
    localparam bit PEN = 1'b1;
`else
    localparam bit PEN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]  txd [3];
    logic        txv [3];
    wire         rdy [3];
    wire         txl [3];
    wire         bsy [3];
    wire  [15:0] fc  [3];

    int CPB [3] = '{1, 4, 1};
    int STB [3] = '{1, 1, 2};
    int ODD [3] = '{0, 0, 1};

    int errs = 0;
    int checks = 0;

    serial_frame_tx u0 (
        .clk(clk), .reset(reset), .tx_data(txd[0]), .tx_valid(txv[0]),
        .tx_ready(rdy[0]), .tx(txl[0]), .busy(bsy[0]), .frame_cnt(fc[0]));

    serial_frame_tx #(.CLKS_PER_BIT(4)) u1 (
        .clk(clk), .reset(reset), .tx_data(txd[1]), .tx_valid(txv[1]),
        .tx_ready(rdy[1]), .tx(txl[1]), .busy(bsy[1]), .frame_cnt(fc[1]));

    serial_frame_tx #(.PARITY_ODD(1), .STOP_BITS(2)) u2 (
        .clk(clk), .reset(reset), .tx_data(txd[2]), .tx_valid(txv[2]),
        .tx_ready(rdy[2]), .tx(txl[2]), .busy(bsy[2]), .frame_cnt(fc[2]));

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Line must hold v for one full bit period of instance u.
    task automatic hold(int u, string tag, logic v);
        repeat (CPB[u]) begin
            @(negedge clk);
            chk($sformatf("u%0d %s", u, tag), {31'd0, txl[u]}, {31'd0, v});
        end
    endtask

    task automatic expect_frame(int u, logic [7:0] d);
        hold(u, "start", 1'b0);
        for (int i = 0; i < 8; i++) hold(u, $sformatf("data%0d", i), d[i]);
        if (PEN) hold(u, "parity", (^d) ^ ODD[u][0]);
        for (int s = 0; s < STB[u]; s++) hold(u, "stop", 1'b1);
    endtask

    task automatic push1(int u, logic [7:0] d);
        @(negedge clk);
        txd[u] = d;
        txv[u] = 1'b1;
        @(posedge clk);
        #1 txv[u] = 1'b0;
        @(negedge clk);
        chk($sformatf("u%0d pre-start idle", u), {31'd0, txl[u]}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int u = 0; u < 3; u++) begin
            txd[u] = 8'h00;
            txv[u] = 1'b0;
        end
        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst tx",        {31'd0, txl[0]}, 32'd1);
        chk("rst ready",     {31'd0, rdy[0]}, 32'd1);
        chk("rst busy",      {31'd0, bsy[0]}, 32'd0);
        chk("rst frame_cnt", {16'd0, fc[0]},  32'd0);

        // Word accepted on the first edge after release.
        reset  = 1'b0;
        txd[0] = 8'h55;
        txv[0] = 1'b1;
        @(posedge clk);
        #1 txv[0] = 1'b0;
        @(negedge clk);
        chk("u0 first idle", {31'd0, txl[0]}, 32'd1);
        chk("u0 busy",       {31'd0, bsy[0]}, 32'd1);
        expect_frame(0, 8'h55);
        @(negedge clk);
        chk("u0 after idle", {31'd0, txl[0]}, 32'd1);
        chk("u0 frame_cnt",  {16'd0, fc[0]},  32'd1);
        chk("u0 busy done",  {31'd0, bsy[0]}, 32'd0);

        push1(2, 8'h07);
        expect_frame(2, 8'h07);
        @(negedge clk);
        chk("u2 idle",      {31'd0, txl[2]}, 32'd1);
        chk("u2 frame_cnt", {16'd0, fc[2]},  32'd1);

        push1(0, 8'h07);
        expect_frame(0, 8'h07);
        @(negedge clk);
        chk("u0 frame_cnt 07", {16'd0, fc[0]}, 32'd2);

        // Each bit held 4 cycles; idle straight after the stop period.
        push1(1, 8'hA0);
        expect_frame(1, 8'hA0);
        @(negedge clk);
        chk("u1 idle",      {31'd0, txl[1]}, 32'd1);
        chk("u1 busy",      {31'd0, bsy[1]}, 32'd0);
        chk("u1 frame_cnt", {16'd0, fc[1]},  32'd1);

        // Fill the buffer: 1..5 accepted, 6 held while full must be dropped.
        fork
            begin
                int w;
                logic a;
                w = 1;
                @(negedge clk);
                while (w <= 5) begin
                    txd[0] = 8'(w);
                    txv[0] = 1'b1;
                    a = rdy[0];
                    @(posedge clk);
                    if (a) w++;
                    @(negedge clk);
                end
                txd[0] = 8'h06;
                repeat (3) begin
                    chk("full ready", {31'd0, rdy[0]}, 32'd0);
                    @(posedge clk);
                    @(negedge clk);
                end
                txv[0] = 1'b0;
            end
            begin
                @(negedge clk);
                @(negedge clk);
                chk("fill first idle", {31'd0, txl[0]}, 32'd1);
                for (int w = 1; w <= 5; w++) expect_frame(0, 8'(w));
                @(negedge clk);
                chk("fill idle",      {31'd0, txl[0]}, 32'd1);
                chk("fill busy",      {31'd0, bsy[0]}, 32'd0);
                chk("fill frame_cnt", {16'd0, fc[0]},  32'd7);
            end
        join

        // Reset during data bit 3 of 8'hF0 (bit 3 is 0 on the line).
        push1(0, 8'hF0);
        repeat (4) @(negedge clk);
        @(posedge clk);
        #2;
        chk("pre-reset bit3", {31'd0, txl[0]}, 32'd0);
        reset = 1'b1;
        #1;
        chk("mid rst tx",        {31'd0, txl[0]}, 32'd1);
        chk("mid rst busy",      {31'd0, bsy[0]}, 32'd0);
        chk("mid rst ready",     {31'd0, rdy[0]}, 32'd1);
        chk("mid rst frame_cnt", {16'd0, fc[0]},  32'd0);
        @(negedge clk);
        reset = 1'b0;
        push1(0, 8'hC3);
        expect_frame(0, 8'hC3);
        @(negedge clk);
        chk("post rst idle",      {31'd0, txl[0]}, 32'd1);
        chk("post rst frame_cnt", {16'd0, fc[0]},  32'd1);

        // Wrap: preload the counter to its last value, then finish one frame.
        @(negedge clk);
        force u0.frame_cnt_q = 16'hFFFF;
        @(negedge clk);
        release u0.frame_cnt_q;
        push1(0, 8'h12);
        expect_frame(0, 8'h12);
        @(negedge clk);
        chk("wrap frame_cnt", {16'd0, fc[0]}, 32'd0);
        chk("wrap idle",      {31'd0, txl[0]}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
